// File: rtl/program_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// program_loader_if
//   Byte-stream handshake into the loader and the instruction-memory write
//   port driven by the loader.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface program_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;

  // Stream source / memory observer side
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// program_loader
//   Boot loader: parses HDR/LEN/DATA/CSUM frames, writes the 16x8
//   instruction memory, pads unused words, checks the XOR checksum and
//   releases the CPU core from reset only after a verified load.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module program_loader #(
  parameter logic [7:0] FILL_WORD = 8'h00,
  parameter logic [7:0] HDR_BYTE  = 8'hA5
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         start,
  program_loader_if.slave   bus,
  output logic              cpu_reset,
  output logic              load_ok,
  output logic              load_err
);

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CSUM  = 3'd3,
    S_FILL  = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;      // data address in DATA, fill address in FILL
  logic [7:0] r_csum, w_csum_nxt;
  logic [4:0] r_len, w_len_nxt;      // 1..16
  logic       r_we, w_we_nxt;
  logic [3:0] r_addr, w_addr_nxt;
  logic [7:0] r_wdata, w_wdata_nxt;
  logic       r_cpu_reset, w_cpu_reset_nxt;
  logic       r_ok, w_ok_nxt;
  logic       r_err, w_err_nxt;
  logic       w_stream_state;
  logic       w_ready;
  logic       w_accept;

  assign w_stream_state = (r_state == S_HDR) || (r_state == S_LEN) ||
                          (r_state == S_DATA) || (r_state == S_CSUM);
  // start wins over a coincident byte, so the source sees not-ready then
  assign w_ready  = w_stream_state && !start;
  assign w_accept = bus.in_valid && w_ready;

  assign bus.in_ready  = w_ready;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign cpu_reset     = r_cpu_reset;
  assign load_ok       = r_ok;
  assign load_err      = r_err;

  // Next-state and next-output decode for the frame parser
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_csum_nxt      = r_csum;
    w_len_nxt       = r_len;
    w_we_nxt        = 1'b0;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_cpu_reset_nxt = 1'b1;
    w_ok_nxt        = 1'b0;
    w_err_nxt       = 1'b0;

    if (start) begin
      w_state_nxt = S_HDR;
      w_cnt_nxt   = 4'd0;
      w_csum_nxt  = 8'd0;
    end else begin
      case (r_state)
        S_HDR: begin
          if (w_accept && (bus.in_data == HDR_BYTE)) begin
            w_state_nxt = S_LEN;
          end
        end
        S_LEN: begin
          if (w_accept) begin
            if ((bus.in_data == 8'd0) || (bus.in_data > 8'd16)) begin
              w_state_nxt = S_ERROR;
            end else begin
              w_len_nxt   = bus.in_data[4:0];
              w_csum_nxt  = bus.in_data;
              w_cnt_nxt   = 4'd0;
              w_state_nxt = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            w_we_nxt    = 1'b1;
            w_addr_nxt  = r_cnt;
            w_wdata_nxt = bus.in_data;
            w_csum_nxt  = r_csum ^ bus.in_data;
            w_cnt_nxt   = r_cnt + 4'd1;
            if ({1'b0, r_cnt} == (r_len - 5'd1)) begin
              w_state_nxt = S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (w_accept) begin
            if (bus.in_data != r_csum) begin
              w_state_nxt = S_ERROR;
            end else if (r_len == 5'd16) begin
              w_state_nxt = S_DONE;
            end else begin
              w_cnt_nxt   = r_len[3:0];
              w_state_nxt = S_FILL;
            end
          end
        end
        S_FILL: begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_cnt;
          w_wdata_nxt = FILL_WORD;
          w_cnt_nxt   = r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          // Core leaves reset one edge after the final write has committed
          w_cpu_reset_nxt = 1'b0;
          w_ok_nxt        = 1'b1;
        end
        S_ERROR: begin
          w_err_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = S_HDR;
        end
      endcase
    end
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_HDR;
      r_cnt       <= 4'd0;
      r_csum      <= 8'd0;
      r_len       <= 5'd0;
      r_we        <= 1'b0;
      r_addr      <= 4'd0;
      r_wdata     <= 8'd0;
      r_cpu_reset <= 1'b1;
      r_ok        <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_csum      <= w_csum_nxt;
      r_len       <= w_len_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_cpu_reset <= w_cpu_reset_nxt;
      r_ok        <= w_ok_nxt;
      r_err       <= w_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_program_loader
//   Directed and randomized frames against a frame-level reference model.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_program_loader;
  logic clk = 1'b0;
  logic reset, start;
  logic cpu_reset, load_ok, load_err;

  program_loader_if bus();

  program_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .load_ok   (load_ok),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [7:0] stim[$];
  logic [3:0] wr_a[$];
  logic [7:0] wr_d[$];
  int         wr_c[$];
  int         acc_c[$];
  logic [7:0] mem[16];
  int         first_low;
  bit         overlap;

  logic [3:0] ex_a[$];
  logic [7:0] ex_d[$];
  bit         ex_ok, ex_err;
  int         ex_nd, ex_dpos, ex_cpos;
  logic [7:0] img[16];

  // Observe committed memory writes and the core reset release
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_a.push_back(bus.mem_addr);
      wr_d.push_back(bus.mem_wdata);
      wr_c.push_back(cyc);
      mem[bus.mem_addr] = bus.mem_wdata;
    end
    if (cpu_reset === 1'b0 && first_low < 0) first_low = cyc;
    if (bus.mem_we === 1'b1 && cpu_reset === 1'b0) overlap = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_a.delete(); wr_d.delete(); wr_c.delete(); acc_c.delete();
    first_low = -1;
    overlap   = 1'b0;
  endtask

  // Frame-level model: expected write list, outcome and final image
  task automatic model();
    int i;
    int len;
    logic [7:0] c;
    ex_a.delete(); ex_d.delete();
    ex_ok = 0; ex_err = 0; ex_nd = 0; ex_dpos = 0; ex_cpos = 0;
    i = 0;
    while (i < stim.size() && stim[i] != 8'hA5) i++;
    i++;
    len = int'(stim[i]);
    if (len == 0 || len > 16) begin
      ex_err = 1;
      return;
    end
    ex_dpos = i + 1;
    c = stim[i];
    for (int j = 0; j < len; j++) begin
      ex_a.push_back(4'(j));
      ex_d.push_back(stim[i + 1 + j]);
      img[j] = stim[i + 1 + j];
      c = c ^ stim[i + 1 + j];
    end
    ex_nd   = len;
    ex_cpos = i + 1 + len;
    if (stim[ex_cpos] != c) begin
      ex_err = 1;
    end else begin
      for (int a = len; a < 16; a++) begin
        ex_a.push_back(4'(a));
        ex_d.push_back(8'h00);
        img[a] = 8'h00;
      end
      ex_ok = 1;
    end
  endtask

  task automatic gen_frame(input bit force_good);
    int g, kind, len;
    logic [7:0] b, c;
    stim.delete();
    g = $urandom_range(0, 3);
    for (int k = 0; k < g; k++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h5A;
      stim.push_back(b);
    end
    stim.push_back(8'hA5);
    kind = force_good ? 2 : $urandom_range(0, 7);
    if (kind == 0) begin
      stim.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(17, 255)));
      return;
    end
    len = $urandom_range(1, 16);
    c = 8'(len);
    stim.push_back(8'(len));
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      c = c ^ b;
      stim.push_back(b);
    end
    if (kind == 1) c = c ^ 8'($urandom_range(1, 255));
    stim.push_back(c);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int gap_max);
    bit got, rdy;
    int waitn;
    for (int k = 0; k < stim.size(); k++) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = stim[k];
      got   = 0;
      waitn = 0;
      while (!got && waitn < 50) begin
        rdy = bus.in_ready;
        @(posedge clk); #1;
        if (rdy) begin
          got = 1;
          acc_c.push_back(cyc);
        end else begin
          waitn++;
          @(negedge clk);
        end
      end
      chk("byte_accepted", 32'(got), 32'd1);
      if (!got) break;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_frame();
    int n;
    n = 0;
    while (!(load_ok === 1'b1 || load_err === 1'b1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("completion_seen", 32'(load_ok | load_err), 32'd1);
    repeat (3) @(negedge clk);
    chk("load_ok", 32'(load_ok), 32'(ex_ok));
    chk("load_err", 32'(load_err), 32'(ex_err));
    chk("cpu_reset", 32'(cpu_reset), 32'(!ex_ok));
    chk("in_ready_terminal", 32'(bus.in_ready), 32'd0);
    chk("write_count", 32'(wr_a.size()), 32'(ex_a.size()));
    chk("write_overlaps_run", 32'(overlap), 32'd0);
    if (wr_a.size() == ex_a.size()) begin
      for (int j = 0; j < ex_a.size(); j++) begin
        chk("write_addr", 32'(wr_a[j]), 32'(ex_a[j]));
        chk("write_data", 32'(wr_d[j]), 32'(ex_d[j]));
      end
      for (int j = 0; j < ex_nd; j++)
        chk("data_write_latency", 32'(wr_c[j]), 32'(acc_c[ex_dpos + j]));
      if (ex_ok && ex_nd < 16) begin
        chk("first_fill_cycle", 32'(wr_c[ex_nd]), 32'(acc_c[ex_cpos] + 1));
        for (int j = ex_nd + 1; j < 16; j++)
          chk("fill_contiguous", 32'(wr_c[j]), 32'(wr_c[j - 1] + 1));
        chk("release_after_last_write", 32'(first_low), 32'(wr_c[15] + 1));
      end
      if (ex_ok && ex_nd == 16)
        chk("release_after_writes", 32'(first_low > wr_c[15]), 32'd1);
    end
    if (ex_ok) begin
      for (int a = 0; a < 16; a++) chk("mem_image", 32'(mem[a]), 32'(img[a]));
    end else begin
      chk("cpu_held_in_reset", 32'(first_low), 32'hFFFF_FFFF);
    end
  endtask

  task automatic run_frame(input bit do_start, input int gap_max);
    if (do_start) pulse_start();
    clear_log();
    model();
    send(gap_max);
    finish_frame();
  endtask

  task automatic abort_mid_data(input bit use_reset);
    pulse_start();
    clear_log();
    stim = '{8'hA5, 8'h04, 8'h11, 8'h22};
    send(0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h33;
    if (use_reset) reset = 1'b1;
    else begin
      start = 1'b1;
      #1 chk("ready_low_on_start", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    clear_log();
    @(negedge clk);
    chk("abort_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
    chk("abort_load_ok", 32'(load_ok), 32'd0);
    gen_frame(1'b1);
    run_frame(1'b0, 2);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    first_low = -1;
    overlap = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_load_ok", 32'(load_ok), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);

    stim = '{8'hA5, 8'h02, 8'h51, 8'h62, 8'h31};
    run_frame(1'b0, 0);

    stim = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
             8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};
    run_frame(1'b1, 0);

    stim = '{8'hA5, 8'h01, 8'h33, 8'h00};
    run_frame(1'b1, 0);

    stim = '{8'hA5, 8'h00};
    run_frame(1'b1, 0);

    stim = '{8'hA5, 8'h11};
    run_frame(1'b1, 0);

    stim = '{8'h12, 8'hFF, 8'hA5, 8'h01, 8'h40, 8'h41};
    run_frame(1'b1, 3);

    for (int r = 0; r < 30; r++) begin
      gen_frame(1'b0);
      run_frame(1'b1, (r % 3 == 0) ? 0 : 3);
    end

    abort_mid_data(1'b0);
    abort_mid_data(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
